// File: rtl/fetch_byte_queue_pkg.sv
// Shared constants for the fetch prefetch byte queue.
// No logic here; sizes of the instruction window and memory word.
package fetch_byte_queue_pkg;

    localparam int          MAX_INSTR_BYTES  = 5;
    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_byte_ring.sv
// Byte ring: DEPTH x 8 storage, 0-4 byte push, 0-5 byte pop, 5-byte head window.
// Push/pop take effect on the next edge; window is combinational from registered state.
module fetch_byte_ring
    import fetch_byte_queue_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic [2:0]    i_push_cnt,
    input  logic [31:0]   i_push_dat,
    input  logic [2:0]    i_pop_cnt,
    output logic [CW-1:0] o_count,
    output logic [39:0]   o_window
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Callers guarantee pop <= count and push <= free, so count never wraps.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(i_pop_cnt);
            r_tail  <= r_tail + AW'(i_push_cnt);
            r_count <= r_count - CW'(i_pop_cnt) + CW'(i_push_cnt);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (!rst && !i_flush && (3'(i) < i_push_cnt)) begin
                r_mem[r_tail + AW'(i)] <= i_push_dat[8*i +: 8];
            end
        end
    end

    // Head byte lands in the top lane; lanes past the fill level read as zero.
    always_comb begin
        o_window = '0;
        for (int i = 0; i < MAX_INSTR_BYTES; i++) begin
            if (CW'(i) < r_count) begin
                o_window[8*(MAX_INSTR_BYTES-1-i) +: 8] = r_mem[r_head + AW'(i)];
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_byte_queue.sv
// Prefetch queue: one-outstanding word fetch into a byte ring, 5-byte window at fetch PC.
// Window is registered-state only; requests stall on halt, outstanding read or < 4 free bytes.
module fetch_byte_queue
    import fetch_byte_queue_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        consume,
    input  logic [2:0]  consume_len,
    output logic        window_valid,
    output logic [39:0] window,
    output logic [31:0] window_pc,
    output logic [4:0]  byte_count,
    output logic        err_consume
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          r_outstanding;
    logic          r_drop;
    logic          r_err;
    logic [1:0]    r_skip;
    logic [31:0]   r_window_pc;
    logic [31:0]   r_req_pc;

    logic [CW-1:0] w_count;
    logic [39:0]   w_window;
    logic          w_free_ok;
    logic          w_accept;
    logic          w_resp;
    logic          w_len_ok;
    logic          w_pop_ok;
    logic          w_push_en;
    logic [2:0]    w_push_cnt;
    logic [31:0]   w_push_dat;
    logic [2:0]    w_pop_cnt;

    assign w_free_ok      = (w_count <= CW'(DEPTH - WORD_BYTES));
    assign imem_req_valid = !rst && !halt && !r_outstanding && w_free_ok;
    assign imem_req_addr  = r_req_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign w_resp         = imem_resp_valid && r_outstanding;

    assign window_valid   = (w_count >= CW'(MAX_INSTR_BYTES));
    assign w_len_ok       = (consume_len != 3'd0) && (consume_len <= 3'(MAX_INSTR_BYTES));
    assign w_pop_ok       = consume && !redirect && window_valid && w_len_ok;
    assign w_pop_cnt      = w_pop_ok ? consume_len : 3'd0;

    // Leading bytes below an unaligned redirect target are shifted out of the first word.
    assign w_push_en      = w_resp && !r_drop && !redirect;
    assign w_push_cnt     = w_push_en ? (3'd4 - {1'b0, r_skip}) : 3'd0;
    assign w_push_dat     = imem_resp_data >> {r_skip, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_err         <= 1'b0;
            r_skip        <= RESET_PC[1:0];
            r_window_pc   <= RESET_PC;
            r_req_pc      <= {RESET_PC[31:2], 2'b00};
        end else if (redirect) begin
            r_window_pc   <= redirect_pc;
            r_req_pc      <= {redirect_pc[31:2], 2'b00};
            r_skip        <= redirect_pc[1:0];
            // Any read still in flight (or issued this cycle) targets the old path.
            r_outstanding <= w_accept || (r_outstanding && !w_resp);
            r_drop        <= w_accept || (r_outstanding && !w_resp);
        end else begin
            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_req_pc + 32'd4;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
                if (r_drop) begin
                    r_drop <= 1'b0;
                end else begin
                    r_skip <= 2'b00;
                end
            end
            if (w_pop_ok) begin
                r_window_pc <= r_window_pc + 32'(consume_len);
            end
            if (consume && !w_pop_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    fetch_byte_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (redirect),
        .i_push_cnt (w_push_cnt),
        .i_push_dat (w_push_dat),
        .i_pop_cnt  (w_pop_cnt),
        .o_count    (w_count),
        .o_window   (w_window)
    );

    assign window      = w_window;
    assign window_pc   = r_window_pc;
    assign byte_count  = window_valid ? 5'd5 : 5'(w_count);
    assign err_consume = r_err;

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: behavioural memory, consume scoreboard, vector tables.
module tb_fetch_byte_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        consume;
    logic [2:0]  consume_len;
    logic        window_valid;
    logic [39:0] window;
    logic [31:0] window_pc;
    logic [4:0]  byte_count;
    logic        err_consume;

    always #5 clk = ~clk;

    fetch_byte_queue dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .consume         (consume),
        .consume_len     (consume_len),
        .window_valid    (window_valid),
        .window          (window),
        .window_pc       (window_pc),
        .byte_count      (byte_count),
        .err_consume     (err_consume)
    );

    typedef struct { logic [31:0] pc; logic [39:0] win; } exp_t;
    typedef struct { logic [2:0] len; logic [31:0] exp_pc; } cvec_t;
    typedef struct { logic [2:0] len; logic want_valid; logic [31:0] exp_pc; } ivec_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    logic        pend = 1'b0;
    int          cd = 0;
    logic [31:0] paddr = '0;
    logic        last_acc = 1'b0;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] model_pc = '0;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (a < 32'd8) return 8'h11 * (a[7:0] + 8'd1);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    function automatic logic [39:0] exp_window(input logic [31:0] pc);
        logic [39:0] w;
        for (int i = 0; i < 5; i++) w[8*(4-i) +: 8] = byte_at(pc + 32'(i));
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: sample the request handshake, cross the edge, then play memory.
    task automatic tick();
        #1;
        last_acc      = imem_req_valid && imem_req_ready;
        last_acc_addr = imem_req_addr;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (last_acc) begin
            pend = 1'b1; paddr = last_acc_addr; cd = lat;
        end
        if (pend) begin
            cd--;
            if (cd <= 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_at(paddr);
                pend            = 1'b0;
            end
        end
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!window_valid && n < 64) begin tick(); n++; end
        if (!window_valid) begin
            checks++; errors++;
            $display("FAIL %s: window_valid timeout got 0 expected 1", nm);
        end
    endtask

    task automatic wait_acc(input string nm);
        int n = 0;
        do begin tick(); n++; end while (!last_acc && n < 64);
        chk(nm, 64'(last_acc), 64'd1);
    endtask

    task automatic do_consume(input logic [2:0] len);
        exp_t e;
        e.pc  = model_pc + 32'(len);
        e.win = exp_window(e.pc);
        sb.push_back(e);
        consume = 1'b1; consume_len = len;
        tick();
        consume = 1'b0;
        model_pc = model_pc + 32'(len);
        wait_valid("consume_refill");
        e = sb.pop_front();
        chk("sb_pc", 64'(window_pc), 64'(e.pc));
        chk("sb_window", 64'(window), 64'(e.win));
    endtask

    task automatic reset_dut();
        rst = 1'b1; redirect = 1'b0; consume = 1'b0; halt = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_pc = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cvec_t ctab[4];
        ivec_t itab[4];
        int    nacc;
        ctab = '{'{3'd3, 32'd3}, '{3'd5, 32'd8}, '{3'd1, 32'd9}, '{3'd4, 32'd13}};
        itab = '{'{3'd0, 1'b1, 32'd0}, '{3'd6, 1'b1, 32'd0},
                 '{3'd7, 1'b1, 32'd0}, '{3'd3, 1'b0, 32'd0}};

        rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0; consume = 1'b0; consume_len = '0;

        // Reset state
        tick(); tick();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_window_valid", 64'(window_valid), 64'd0);
        chk("rst_window", 64'(window), 64'd0);
        chk("rst_byte_count", 64'(byte_count), 64'd0);
        chk("rst_err", 64'(err_consume), 64'd0);
        chk("rst_window_pc", 64'(window_pc), 64'd0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", 64'(imem_req_addr), 64'd0);

        // First window
        wait_valid("first_fill");
        chk("first_window", 64'(window), 64'h11_2233_4455);
        chk("first_pc", 64'(window_pc), 64'd0);
        chk("first_count", 64'(byte_count), 64'd5);

        // Consume table
        for (int i = 0; i < 4; i++) begin
            do_consume(ctab[i].len);
            chk("tab_pc", 64'(window_pc), 64'(ctab[i].exp_pc));
            if (i == 0) chk("tab_window_pc3", 64'(window), 64'h44_5566_7788);
        end
        chk("legal_no_err", 64'(err_consume), 64'd0);

        // Redirect with a read outstanding: stale word must be dropped
        lat = 4;
        wait_acc("pre_redirect_acc");
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        lat = 1;
        chk("redir_valid", 64'(window_valid), 64'd0);
        chk("redir_count", 64'(byte_count), 64'd0);
        chk("redir_pc", 64'(window_pc), 64'h102);
        wait_acc("redir_acc");
        chk("redir_req_addr", 64'(last_acc_addr), 64'h100);
        model_pc = 32'h102;
        wait_valid("redir_fill");
        chk("redir_window", 64'(window), 64'(exp_window(32'h102)));
        chk("redir_window_pc", 64'(window_pc), 64'h102);

        // Fill with no consume: requests must stop once fewer than 4 bytes are free
        repeat (30) tick();
        chk("full_req_valid", 64'(imem_req_valid), 64'd0);
        chk("full_count", 64'(byte_count), 64'd5);
        nacc = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (last_acc) nacc++; end
        chk("full_no_acc", 64'(nacc), 64'd0);
        chk("full_window", 64'(window), 64'(exp_window(32'h102)));
        do_consume(3'd5);
        wait_acc("resume_acc");

        // Pointer wrap: long random consume run
        for (int k = 0; k < 100; k++) do_consume(3'($urandom_range(1, 5)));
        chk("wrap_no_err", 64'(err_consume), 64'd0);

        // Halt: no new requests, window held, consume still honoured
        repeat (10) tick();
        halt = 1'b1;
        tick();
        chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
        nacc = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (last_acc) nacc++; end
        chk("halt_no_acc", 64'(nacc), 64'd0);
        chk("halt_window", 64'(window), 64'(exp_window(model_pc)));
        do_consume(3'd2);
        halt = 1'b0;

        // Redirect, response and consume in one cycle: only the redirect counts
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        model_pc = 32'h300;
        wait_valid("r300_fill");
        chk("r300_window", 64'(window), 64'(exp_window(32'h300)));
        wait_acc("combo_acc");
        chk("combo_pre_valid", 64'(window_valid), 64'd1);
        redirect = 1'b1; redirect_pc = 32'h2001; consume = 1'b1; consume_len = 3'd3;
        tick();
        redirect = 1'b0; consume = 1'b0;
        chk("combo_pc", 64'(window_pc), 64'h2001);
        chk("combo_valid", 64'(window_valid), 64'd0);
        chk("combo_err", 64'(err_consume), 64'd0);
        model_pc = 32'h2001;
        wait_valid("combo_fill");
        chk("combo_window", 64'(window), 64'(exp_window(32'h2001)));

        // Illegal consumes
        for (int i = 0; i < 4; i++) begin
            reset_dut();
            if (itab[i].want_valid) wait_valid("ill_fill");
            chk("ill_pre_err", 64'(err_consume), 64'd0);
            consume = 1'b1; consume_len = itab[i].len;
            tick();
            consume = 1'b0;
            chk("ill_err", 64'(err_consume), 64'd1);
            chk("ill_pc", 64'(window_pc), 64'(itab[i].exp_pc));
            if (itab[i].want_valid) chk("ill_window", 64'(window), 64'(exp_window(32'd0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
